// File: rtl/pipeline_sequencer.sv
// Run-control FSM for the 5-stage RV32I core: load -> scrub -> run -> halt, with per-stage enables and flushes.
// State changes take one clk; enables/flushes decode the state plus same-cycle hazard/branch/halt inputs.
module pipeline_sequencer #(
    parameter int DMEM_WORDS   = 256,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_wr_valid,
    input  logic             load_done,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             halt_retired,
    input  logic             wb_valid,
    input  logic             pause_req,
    input  logic             resume_req,
    input  logic             step_req,
    output logic             if_en,
    output logic             id_en,
    output logic             ex_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             flush_mem,
    output logic [31:0]      scrub_addr,
    output logic             reg_scrub_we,
    output logic             dmem_scrub_we,
    output logic             running,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SCRUB = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_HALT  = 3'd5,
        ST_STEP  = 3'd6
    } state_t;

    localparam int               DRN_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [31:0]      SCRUB_LAST = 32'(DMEM_WORDS - 1);
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(DRAIN_CYCLES - 1);

    state_t           state_q;
    logic [31:0]      scrub_q;
    logic [DRN_W-1:0] drain_q;
    logic             load_done_q;
    logic             load_edge;

    assign load_edge     = load_done && !load_done_q;
    assign state         = state_q;
    assign scrub_addr    = scrub_q;
    assign running       = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign dmem_scrub_we = (state_q == ST_SCRUB);
    assign reg_scrub_we  = dmem_scrub_we && (scrub_q < 32'd32);

    // A taken branch redirects the PC, so it overrides a hazard stall; a retiring halt squashes everything younger.
    always_comb begin
        if_en     = 1'b0;
        id_en     = 1'b0;
        ex_en     = 1'b0;
        mem_en    = 1'b0;
        wb_en     = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        flush_mem = 1'b0;
        case (state_q)
            ST_RUN, ST_STEP: begin
                if_en  = 1'b1;
                id_en  = 1'b1;
                ex_en  = 1'b1;
                mem_en = 1'b1;
                wb_en  = 1'b1;
                if (branch_taken) begin
                    flush_id  = 1'b1;
                    flush_ex  = 1'b1;
                    flush_mem = 1'b1;
                end else if (hazard_detected) begin
                    if_en    = 1'b0;
                    id_en    = 1'b0;
                    flush_ex = 1'b1;
                end
                if (halt_retired) begin
                    if_en     = 1'b0;
                    id_en     = 1'b1;
                    flush_id  = 1'b1;
                    flush_ex  = 1'b1;
                    flush_mem = 1'b1;
                end
            end
            ST_DRAIN: begin
                id_en    = 1'b1;
                ex_en    = 1'b1;
                mem_en   = 1'b1;
                wb_en    = 1'b1;
                flush_id = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            scrub_q     <= '0;
            drain_q     <= '0;
            load_done_q <= 1'b0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            load_done_q <= load_done;
            if (running)
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (wb_valid && wb_en)
                instret_cnt <= instret_cnt + CNT_W'(1);

            case (state_q)
                ST_IDLE: begin
                    if (instr_wr_valid)
                        state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (load_edge) begin
                        state_q     <= ST_SCRUB;
                        scrub_q     <= '0;
                        cycle_cnt   <= '0;
                        instret_cnt <= '0;
                    end
                end
                ST_SCRUB: begin
                    if (scrub_q == SCRUB_LAST) begin
                        state_q <= ST_RUN;
                        scrub_q <= '0;
                    end else begin
                        scrub_q <= scrub_q + 32'd1;
                    end
                end
                ST_RUN: begin
                    if (instr_wr_valid) begin
                        state_q <= ST_LOAD;
                    end else if (halt_retired) begin
                        state_q <= ST_HALT;
                    end else if (pause_req) begin
                        state_q <= ST_DRAIN;
                        drain_q <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (instr_wr_valid)
                        state_q <= ST_LOAD;
                    else if (halt_retired || drain_q == DRAIN_LAST)
                        state_q <= ST_HALT;
                    else
                        drain_q <= drain_q + DRN_W'(1);
                end
                ST_HALT: begin
                    if (instr_wr_valid)
                        state_q <= ST_LOAD;
                    else if (resume_req)
                        state_q <= ST_RUN;
                    else if (step_req)
                        state_q <= ST_STEP;
                end
                ST_STEP: begin
                    // A stalled fetch means the step has not happened yet, so stay here.
                    if (instr_wr_valid) begin
                        state_q <= ST_LOAD;
                    end else if (halt_retired) begin
                        state_q <= ST_HALT;
                    end else if (!(hazard_detected && !branch_taken)) begin
                        state_q <= ST_DRAIN;
                        drain_q <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed-vector bench for pipeline_sequencer; expectations queued by stimulus, popped by a negedge monitor.
module tb_pipeline_sequencer;
    localparam int DMEM_WORDS   = 256;
    localparam int DRAIN_CYCLES = 4;
    localparam int CNT_W        = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic instr_wr_valid, load_done, hazard_detected, branch_taken, halt_retired;
    logic wb_valid, pause_req, resume_req, step_req;
    logic if_en, id_en, ex_en, mem_en, wb_en, flush_id, flush_ex, flush_mem;
    logic [31:0] scrub_addr;
    logic reg_scrub_we, dmem_scrub_we, running;
    logic [2:0] state;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;

    always #5 clk = ~clk;

    pipeline_sequencer #(
        .DMEM_WORDS(DMEM_WORDS), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_wr_valid(instr_wr_valid), .load_done(load_done),
        .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .halt_retired(halt_retired), .wb_valid(wb_valid),
        .pause_req(pause_req), .resume_req(resume_req), .step_req(step_req),
        .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en), .wb_en(wb_en),
        .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem),
        .scrub_addr(scrub_addr), .reg_scrub_we(reg_scrub_we), .dmem_scrub_we(dmem_scrub_we),
        .running(running), .state(state), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    typedef enum int {S_STATE, S_EN, S_IFEN, S_EXWB, S_FLUSH, S_SCRUB, S_ADDR, S_RUN, S_CYC, S_INSTRET} sel_t;
    typedef struct {
        int          cyc;
        sel_t        sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   tcyc   = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always @(posedge clk) tcyc <= tcyc + 1;

    function automatic logic [31:0] actual(sel_t s);
        case (s)
            S_STATE:   return {29'd0, state};
            S_EN:      return {27'd0, if_en, id_en, ex_en, mem_en, wb_en};
            S_IFEN:    return {31'd0, if_en};
            S_EXWB:    return {29'd0, ex_en, mem_en, wb_en};
            S_FLUSH:   return {29'd0, flush_id, flush_ex, flush_mem};
            S_SCRUB:   return {30'd0, reg_scrub_we, dmem_scrub_we};
            S_ADDR:    return scrub_addr;
            S_RUN:     return {31'd0, running};
            S_CYC:     return cycle_cnt;
            S_INSTRET: return instret_cnt;
            default:   return 32'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_chk(input sel_t s, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc  = tcyc;
        e.sel  = s;
        e.val  = v;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    // Monitor: every cycle, compare the outputs against whatever was queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].cyc <= tcyc) begin
                e = sb_q.pop_front();
                n_chk++;
                if (e.cyc < tcyc) begin
                    n_fail++;
                    $display("FAIL %s: never sampled in cycle %0d (now %0d)", e.name, e.cyc, tcyc);
                end else if (actual(e.sel) !== e.val) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", e.name, e.cyc, actual(e.sel), e.val);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        {instr_wr_valid, load_done, hazard_detected, branch_taken, halt_retired} = '0;
        {wb_valid, pause_req, resume_req, step_req} = '0;

        tick();
        exp_chk(S_STATE, 32'd0, "rst_state");
        exp_chk(S_EN, 32'd0, "rst_en");
        exp_chk(S_FLUSH, 32'd0, "rst_flush");
        exp_chk(S_SCRUB, 32'd0, "rst_scrub");
        exp_chk(S_ADDR, 32'd0, "rst_addr");
        exp_chk(S_RUN, 32'd0, "rst_running");
        exp_chk(S_CYC, 32'd0, "rst_cycle_cnt");
        exp_chk(S_INSTRET, 32'd0, "rst_instret");
        tick();
        rst_n = 1'b1;

        // Load three words, then a load_done rising edge.
        exp_chk(S_STATE, 32'd0, "idle_state");
        instr_wr_valid = 1'b1;
        exp_chk(S_EN, 32'd0, "idle_en");
        tick();
        exp_chk(S_STATE, 32'd1, "load_state");
        exp_chk(S_EN, 32'd0, "load_en");
        exp_chk(S_SCRUB, 32'd0, "load_scrub");
        tick();
        tick();
        instr_wr_valid = 1'b0;
        tick();
        load_done = 1'b1;
        exp_chk(S_STATE, 32'd1, "load_wait");
        tick();

        for (int i = 0; i < DMEM_WORDS; i++) begin
            exp_chk(S_STATE, 32'd2, "scrub_state");
            exp_chk(S_ADDR, 32'(i), "scrub_addr");
            exp_chk(S_SCRUB, (i < 32) ? 32'd3 : 32'd1, "scrub_we");
            exp_chk(S_EN, 32'd0, "scrub_en");
            tick();
        end

        // R0: first RUN cycle
        exp_chk(S_STATE, 32'd3, "run_entry");
        exp_chk(S_RUN, 32'd1, "run_running");
        exp_chk(S_SCRUB, 32'd0, "run_scrub_off");
        exp_chk(S_ADDR, 32'd0, "run_addr");
        exp_chk(S_EN, 32'h1F, "run_en");
        exp_chk(S_FLUSH, 32'd0, "run_flush");
        exp_chk(S_CYC, 32'd0, "run_cyc0");
        tick();
        hazard_detected = 1'b1;
        exp_chk(S_EN, 32'h07, "hazard_en");
        exp_chk(S_FLUSH, 32'h2, "hazard_flush");
        tick();
        hazard_detected = 1'b0;
        branch_taken = 1'b1;
        exp_chk(S_EN, 32'h1F, "branch_en");
        exp_chk(S_FLUSH, 32'h7, "branch_flush");
        tick();
        hazard_detected = 1'b1;
        exp_chk(S_IFEN, 32'd1, "hzbr_if_en");
        exp_chk(S_FLUSH, 32'h7, "hzbr_flush");
        tick();
        hazard_detected = 1'b0;
        branch_taken = 1'b0;
        wb_valid = 1'b1;
        exp_chk(S_CYC, 32'd4, "run_cyc4");
        exp_chk(S_INSTRET, 32'd0, "run_instret0");
        exp_chk(S_FLUSH, 32'd0, "run_noflush");
        tick();
        pause_req = 1'b1;
        exp_chk(S_STATE, 32'd3, "pause_cycle_state");
        exp_chk(S_CYC, 32'd5, "pause_cycle_cnt");
        exp_chk(S_INSTRET, 32'd1, "pause_instret");
        tick();
        pause_req = 1'b0;
        exp_chk(S_STATE, 32'd4, "drain1_state");
        exp_chk(S_IFEN, 32'd0, "drain1_if");
        exp_chk(S_EXWB, 32'h7, "drain1_exwb");
        exp_chk(S_FLUSH, 32'h4, "drain1_flush");
        exp_chk(S_CYC, 32'd6, "drain1_cyc");
        exp_chk(S_RUN, 32'd0, "drain1_running");
        exp_chk(S_INSTRET, 32'd2, "drain1_instret");
        tick();
        branch_taken = 1'b1;
        exp_chk(S_STATE, 32'd4, "drain2_state");
        exp_chk(S_IFEN, 32'd0, "drain_branch_if");
        exp_chk(S_FLUSH, 32'h4, "drain_branch_flush");
        tick();
        branch_taken = 1'b0;
        exp_chk(S_STATE, 32'd4, "drain3_state");
        tick();
        exp_chk(S_STATE, 32'd4, "drain4_state");
        exp_chk(S_CYC, 32'd6, "drain4_cyc");
        tick();
        wb_valid = 1'b0;
        exp_chk(S_STATE, 32'd5, "halt_after_drain");
        exp_chk(S_EN, 32'd0, "halt_en");
        exp_chk(S_CYC, 32'd6, "halt_cyc");
        exp_chk(S_INSTRET, 32'd6, "halt_instret");

        // Single step without a hazard.
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        exp_chk(S_STATE, 32'd6, "step_state");
        exp_chk(S_IFEN, 32'd1, "step_if");
        exp_chk(S_RUN, 32'd1, "step_running");
        exp_chk(S_EN, 32'h1F, "step_en");
        for (int i = 0; i < DRAIN_CYCLES; i++) begin
            tick();
            exp_chk(S_STATE, 32'd4, "step_drain_state");
            exp_chk(S_IFEN, 32'd0, "step_drain_if");
        end
        tick();
        exp_chk(S_STATE, 32'd5, "step_back_halt");
        exp_chk(S_IFEN, 32'd0, "step_halt_if");
        exp_chk(S_CYC, 32'd7, "step_cyc");

        // Single step that first meets a hazard.
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        hazard_detected = 1'b1;
        exp_chk(S_STATE, 32'd6, "stephz_state");
        exp_chk(S_IFEN, 32'd0, "stephz_if");
        tick();
        hazard_detected = 1'b0;
        exp_chk(S_STATE, 32'd6, "stephz_repeat");
        exp_chk(S_IFEN, 32'd1, "stephz_if_adv");
        tick();
        exp_chk(S_STATE, 32'd4, "stephz_drain");
        repeat (DRAIN_CYCLES) tick();
        exp_chk(S_STATE, 32'd5, "stephz_halt");
        exp_chk(S_CYC, 32'd9, "stephz_cyc");

        // resume and step together: resume wins
        resume_req = 1'b1;
        step_req = 1'b1;
        tick();
        resume_req = 1'b0;
        step_req = 1'b0;
        exp_chk(S_STATE, 32'd3, "resume_wins");
        exp_chk(S_RUN, 32'd1, "resume_running");
        tick();
        halt_retired = 1'b1;
        pause_req = 1'b1;
        wb_valid = 1'b1;
        exp_chk(S_FLUSH, 32'h7, "halt_flush");
        exp_chk(S_EXWB, 32'h7, "halt_wb_en");
        tick();
        halt_retired = 1'b0;
        pause_req = 1'b0;
        wb_valid = 1'b0;
        exp_chk(S_STATE, 32'd5, "halt_no_drain");
        exp_chk(S_INSTRET, 32'd7, "instret_ebreak");
        exp_chk(S_CYC, 32'd11, "halt_cyc11");

        // Reload from RUN.
        resume_req = 1'b1;
        tick();
        resume_req = 1'b0;
        exp_chk(S_STATE, 32'd3, "pre_reload_state");
        exp_chk(S_EN, 32'h1F, "pre_reload_en");
        instr_wr_valid = 1'b1;
        load_done = 1'b0;
        tick();
        instr_wr_valid = 1'b0;
        exp_chk(S_STATE, 32'd1, "reload_state");
        exp_chk(S_EN, 32'd0, "reload_en");
        tick();
        load_done = 1'b1;
        tick();
        exp_chk(S_STATE, 32'd2, "rescrub_state");
        exp_chk(S_CYC, 32'd0, "rescrub_cyc_clr");
        exp_chk(S_INSTRET, 32'd0, "rescrub_instret_clr");
        repeat (16) tick();
        exp_chk(S_ADDR, 32'd16, "pre_rst_addr");
        tick();
        rst_n = 1'b0;
        exp_chk(S_STATE, 32'd0, "midrst_state");
        exp_chk(S_SCRUB, 32'd0, "midrst_scrub_we");
        exp_chk(S_ADDR, 32'd0, "midrst_addr");
        tick();
        exp_chk(S_STATE, 32'd0, "midrst_hold");
        tick();
        rst_n = 1'b1;
        load_done = 1'b0;
        tick();
        exp_chk(S_STATE, 32'd0, "post_rst_idle");
        tick();
        tick();
        @(negedge clk);
        #1;
        while (sb_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d left unchecked", sb_q[0].name, sb_q[0].cyc);
            void'(sb_q.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
